// File: rtl/line_fill_unit.sv
// Line fill / writeback engine: moves one cache line between memory and the
// data array as a burst of s_line/s_burst beats.
module line_fill_unit #(
    parameter int unsigned s_offset = 5,
    parameter int unsigned s_index  = 3,
    parameter int unsigned s_mask   = 2**s_offset,
    parameter int unsigned s_line   = 8*s_mask,
    parameter int unsigned s_burst  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                read_req,
    input  logic                write_req,
    input  logic [31:0]         req_addr,
    input  logic [s_index-1:0]  req_index,
    input  logic [s_line-1:0]   evict_line,
    output logic                busy,
    output logic                done,
    output logic [s_mask-1:0]   da_write_en,
    output logic [s_index-1:0]  da_index,
    output logic [s_line-1:0]   da_datain,
    output logic                mem_read,
    output logic                mem_write,
    output logic [31:0]         mem_address,
    input  logic [s_burst-1:0]  mem_rdata,
    output logic [s_burst-1:0]  mem_wdata,
    input  logic                mem_resp
);

    localparam int unsigned Beats     = s_line / s_burst;
    localparam int unsigned BeatBytes = s_burst / 8;
    localparam int unsigned BeatW     = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [BeatW-1:0] LastBeat  = BeatW'(Beats - 1);
    localparam logic [31:0]      AlignMask = ~((32'd1 << s_offset) - 32'd1);

    typedef enum logic [1:0] {StIdle, StFill, StWb, StDone} state_e;

    state_e              state_q, state_d;
    logic [BeatW-1:0]    beat_q, beat_d;
    logic [31:0]         addr_q, addr_d;
    logic [s_index-1:0]  index_q, index_d;
    logic [s_line-1:0]   evict_q, evict_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;

    // State and request-context registers; reset wins over any pending request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            addr_q      <= '0;
            index_q     <= '0;
            evict_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            addr_q      <= addr_d;
            index_q     <= index_d;
            evict_q     <= evict_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    // Next-state: accept in idle (writeback first), count beats, one-cycle done.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        index_d = index_q;
        evict_d = evict_q;
        unique case (state_q)
            StIdle: begin
                if (write_req || read_req) begin
                    state_d = write_req ? StWb : StFill;
                    beat_d  = '0;
                    addr_d  = req_addr & AlignMask;
                    index_d = req_index;
                    evict_d = evict_line;
                end
            end
            StFill, StWb: begin
                if (mem_resp) begin
                    if (beat_q == LastBeat) begin
                        state_d = StDone;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BeatW'(1);
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Memory strobes are registered copies of the next state.
        mem_read_d  = (state_d == StFill);
        mem_write_d = (state_d == StWb);
    end

    // Outputs: byte enables follow mem_resp combinationally; writes are
    // suppressed while reset is asserted so an aborted fill stops at once.
    always_comb begin
        da_write_en = '0;
        mem_wdata   = '0;
        for (int i = 0; i < int'(Beats); i++) begin
            if (beat_q == BeatW'(i)) begin
                if (state_q == StFill && mem_resp && !rst) begin
                    da_write_en[i*BeatBytes +: BeatBytes] = '1;
                end
                mem_wdata = evict_q[i*s_burst +: s_burst];
            end
        end
    end

    assign da_datain   = {Beats{mem_rdata}};
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = addr_q;
    assign da_index    = index_q;

endmodule

// File: tb/tb_line_fill_unit.sv
// Self-checking bench for line_fill_unit: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_line_fill_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic         read_req, write_req;
    logic [31:0]  req_addr;
    logic [2:0]   req_index;
    logic [255:0] evict_line;
    logic         busy, done;
    logic [31:0]  da_write_en;
    logic [2:0]   da_index;
    logic [255:0] da_datain;
    logic         mem_read, mem_write;
    logic [31:0]  mem_address;
    logic [63:0]  mem_rdata, mem_wdata;
    logic         mem_resp;

    int compared = 0;
    int mismatched = 0;

    line_fill_unit dut (
        .clk(clk), .rst(rst), .read_req(read_req), .write_req(write_req),
        .req_addr(req_addr), .req_index(req_index), .evict_line(evict_line),
        .busy(busy), .done(done), .da_write_en(da_write_en), .da_index(da_index),
        .da_datain(da_datain), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    // Data array image built from what the DUT actually writes.
    logic [255:0] tb_array [8];
    int           write_cycles = 0;
    always @(negedge clk) begin
        if (da_write_en != 32'h0) write_cycles <= write_cycles + 1;
        for (int b = 0; b < 32; b++) begin
            if (da_write_en[b]) tb_array[da_index][b*8 +: 8] <= da_datain[b*8 +: 8];
        end
    end

    // Reference model: one outstanding transfer, described by its kind and
    // how many beats have moved so far.
    int           m_op;      // 0 idle, 1 fill in flight, 2 writeback in flight, 3 done cycle
    int           m_kind;    // kind of the most recent transfer (1 fill, 2 writeback)
    int           m_beat;
    logic [31:0]  m_addr;
    logic [2:0]   m_index;
    logic [255:0] m_evict;
    logic [255:0] m_fill_line;

    task automatic model_tick();
        if (rst) begin
            m_op = 0; m_beat = 0; m_addr = 0; m_index = 0;
        end else if (m_op == 0) begin
            if (write_req || read_req) begin
                m_op    = write_req ? 2 : 1;
                m_kind  = m_op;
                m_beat  = 0;
                m_addr  = {req_addr[31:5], 5'b0};
                m_index = req_index;
                m_evict = evict_line;
            end
        end else if (m_op == 3) begin
            m_op = 0;
        end else if (mem_resp) begin
            if (m_op == 1) m_fill_line[m_beat*64 +: 64] = mem_rdata;
            m_beat++;
            if (m_beat == 4) begin
                m_op = 3; m_beat = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic quiet_inputs();
        rst = 0; read_req = 0; write_req = 0; mem_resp = 0;
        req_addr = 0; req_index = 0; evict_line = 0; mem_rdata = 0;
    endtask

    // Drive responses until the model is back in idle (bounded).
    task automatic finish_op();
        for (int i = 0; i < 20 && m_op != 0; i++) begin
            mem_resp = 1'b1;
            tick();
        end
        mem_resp = 1'b0;
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic test_reset();
        quiet_inputs();
        rst = 1; read_req = 1; write_req = 1; req_addr = 32'hFFFF_FFFF; req_index = 3'd7;
        mem_resp = 1;
        tick(); tick();
        for (int c = 0; c < 2; c++) begin
            compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset.busy got=%0b exp=0", busy); end
            compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset.done got=%0b exp=0", done); end
            compared++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
                mismatched++; $display("FAIL reset.mem_rw got=%0b%0b exp=00", mem_read, mem_write); end
            compared++; if (da_write_en !== 32'h0) begin mismatched++; $display("FAIL reset.we got=%h exp=0", da_write_en); end
            compared++; if (mem_address !== 32'h0 || da_index !== 3'd0) begin
                mismatched++; $display("FAIL reset.addr got=%h/%0d exp=0/0", mem_address, da_index); end
            tick();
        end
        quiet_inputs();
        tick();
    endtask

    task automatic test_fill();
        logic [63:0]  w [4];
        logic [255:0] want_line;
        w[0] = 64'h1111_1111_1111_1111; w[1] = 64'h2222_2222_2222_2222;
        w[2] = 64'h3333_3333_3333_3333; w[3] = 64'h4444_4444_4444_4444;
        want_line = {w[3], w[2], w[1], w[0]};
        read_req = 1; req_addr = 32'h0000_1234; req_index = 3'd2;
        tick();
        read_req = 0; req_addr = 0; req_index = 0;
        for (int k = 0; k < 4; k++) begin
            mem_resp = 1; mem_rdata = w[k];
            #1;
            compared++; if (mem_address !== 32'h0000_1220) begin
                mismatched++; $display("FAIL fill.addr got=%h exp=00001220", mem_address); end
            compared++; if (da_index !== 3'd2) begin mismatched++; $display("FAIL fill.index got=%0d exp=2", da_index); end
            compared++; if (mem_read !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                mismatched++; $display("FAIL fill.ctl beat%0d rd/busy/done got=%0b%0b%0b exp=110", k, mem_read, busy, done); end
            compared++; if (da_write_en !== (32'hFF << (8*k))) begin
                mismatched++; $display("FAIL fill.we beat%0d got=%h exp=%h", k, da_write_en, 32'hFF << (8*k)); end
            compared++; if (da_datain !== {4{w[k]}}) begin
                mismatched++; $display("FAIL fill.datain beat%0d got=%h", k, da_datain); end
            tick();
        end
        mem_resp = 0;
        #1;
        compared++; if (done !== 1'b1 || busy !== 1'b1 || mem_read !== 1'b0 || da_write_en !== 32'h0) begin
            mismatched++; $display("FAIL fill.done_cycle done/busy/rd/we got=%0b%0b%0b/%h exp=110/0", done, busy, mem_read, da_write_en); end
        compared++; if (tb_array[2] !== want_line) begin
            mismatched++; $display("FAIL fill.line got=%h exp=%h", tb_array[2], want_line); end
        tick();
        compared++; if (done !== 1'b0 || busy !== 1'b0) begin
            mismatched++; $display("FAIL fill.after_done done/busy got=%0b%0b exp=00", done, busy); end
    endtask

    task automatic test_writeback();
        logic [63:0] w [4];
        logic [31:0] a;
        for (int k = 0; k < 4; k++) w[k] = {$urandom, $urandom};
        a = $urandom;
        write_req = 1; req_addr = a; req_index = 3'd5; evict_line = {w[3], w[2], w[1], w[0]};
        tick();
        write_req = 0; evict_line = rand_line();
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < 3; g++) begin
                mem_resp = (g == 2);
                #1;
                compared++; if (mem_wdata !== w[k]) begin
                    mismatched++; $display("FAIL wb.wdata beat%0d got=%h exp=%h", k, mem_wdata, w[k]); end
                compared++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || da_write_en !== 32'h0) begin
                    mismatched++; $display("FAIL wb.ctl beat%0d wr/rd/we got=%0b%0b/%h exp=10/0", k, mem_write, mem_read, da_write_en); end
                compared++; if (mem_address !== {a[31:5], 5'b0}) begin
                    mismatched++; $display("FAIL wb.addr got=%h exp=%h", mem_address, {a[31:5], 5'b0}); end
                tick();
            end
        end
        mem_resp = 0;
        #1;
        compared++; if (done !== 1'b1 || mem_write !== 1'b0) begin
            mismatched++; $display("FAIL wb.done done/wr got=%0b%0b exp=10", done, mem_write); end
        tick();
    endtask

    task automatic test_priority();
        int saw_read = 0;
        read_req = 1; write_req = 1; req_addr = $urandom; evict_line = rand_line();
        tick();
        read_req = 0; write_req = 0;
        for (int k = 0; k < 5; k++) begin
            mem_resp = 1;
            #1;
            if (mem_read) saw_read++;
            if (k == 0) begin
                compared++; if (mem_write !== 1'b1) begin
                    mismatched++; $display("FAIL prio.wb_entered got=%0b exp=1", mem_write); end
            end
            tick();
        end
        mem_resp = 0;
        compared++; if (saw_read !== 0) begin
            mismatched++; $display("FAIL prio.mem_read cycles got=%0d exp=0", saw_read); end
        finish_op();
    endtask

    task automatic test_reset_mid();
        int writes_before;
        read_req = 1; req_addr = 32'h0000_4000; req_index = 3'd6;
        tick();
        read_req = 0;
        for (int k = 0; k < 2; k++) begin
            mem_resp = 1; mem_rdata = {$urandom, $urandom};
            tick();
        end
        rst = 1; mem_resp = 1;
        #1;
        compared++; if (da_write_en !== 32'h0) begin
            mismatched++; $display("FAIL rstmid.we_in_reset got=%h exp=0", da_write_en); end
        writes_before = write_cycles;
        tick();
        rst = 0;
        for (int c = 0; c < 3; c++) begin
            mem_resp = 1;
            #1;
            compared++; if (busy !== 1'b0 || mem_read !== 1'b0 || da_write_en !== 32'h0) begin
                mismatched++; $display("FAIL rstmid.idle c%0d busy/rd/we got=%0b%0b/%h exp=00/0", c, busy, mem_read, da_write_en); end
            tick();
        end
        mem_resp = 0;
        compared++; if (write_cycles !== writes_before) begin
            mismatched++; $display("FAIL rstmid.array_writes got=%0d exp=%0d", write_cycles, writes_before); end
        compared++; if (mem_address !== 32'h0 || da_index !== 3'd0) begin
            mismatched++; $display("FAIL rstmid.regs addr/idx got=%h/%0d exp=0/0", mem_address, da_index); end
    endtask

    task automatic test_hold_request();
        logic [31:0] first;
        first = $urandom;
        read_req = 1; req_addr = first; req_index = 3'd1;
        tick();
        for (int k = 0; k < 4; k++) begin
            req_addr = $urandom; write_req = $urandom_range(0, 1); mem_resp = 1;
            #1;
            compared++; if (mem_address !== {first[31:5], 5'b0} || mem_read !== 1'b1) begin
                mismatched++; $display("FAIL hold.no_reaccept beat%0d addr/rd got=%h/%0b exp=%h/1", k, mem_address, mem_read, {first[31:5], 5'b0}); end
            tick();
        end
        write_req = 0; mem_resp = 0;
        #1;
        compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL hold.done got=%0b exp=1", done); end
        tick();
        #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL hold.idle_gap busy got=%0b exp=0", busy); end
        first = req_addr;
        tick();
        read_req = 0;
        #1;
        compared++; if (mem_read !== 1'b1 || mem_address !== {first[31:5], 5'b0}) begin
            mismatched++; $display("FAIL hold.reaccept rd/addr got=%0b/%h exp=1/%h", mem_read, mem_address, {first[31:5], 5'b0}); end
        finish_op();
        for (int c = 0; c < 3; c++) begin
            mem_resp = 1;
            #1;
            compared++; if (busy !== 1'b0 || da_write_en !== 32'h0 || done !== 1'b0) begin
                mismatched++; $display("FAIL hold.stray_resp busy/we/done got=%0b/%h/%0b exp=0/0/0", busy, da_write_en, done); end
            tick();
        end
        mem_resp = 0;
    endtask

    task automatic test_random();
        logic [31:0] e_we;
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            read_req = ($urandom_range(0, 3) == 0);
            write_req = ($urandom_range(0, 5) == 0);
            req_addr = $urandom; req_index = 3'($urandom);
            evict_line = rand_line();
            mem_resp = 1'($urandom); mem_rdata = {$urandom, $urandom};
            #1;
            e_we = (m_op == 1 && mem_resp && !rst) ? (32'hFF << (8*m_beat)) : 32'h0;
            compared++; if (busy !== (m_op != 0) || done !== (m_op == 3)) begin
                mismatched++; $display("FAIL rand.status n=%0d busy/done got=%0b%0b exp=%0b%0b", n, busy, done, m_op != 0, m_op == 3); end
            compared++; if (mem_read !== (m_op == 1) || mem_write !== (m_op == 2)) begin
                mismatched++; $display("FAIL rand.mem_rw n=%0d got=%0b%0b exp=%0b%0b", n, mem_read, mem_write, m_op == 1, m_op == 2); end
            compared++; if (da_write_en !== e_we) begin
                mismatched++; $display("FAIL rand.we n=%0d got=%h exp=%h", n, da_write_en, e_we); end
            compared++; if (da_datain !== {4{mem_rdata}}) begin
                mismatched++; $display("FAIL rand.datain n=%0d got=%h", n, da_datain); end
            compared++; if (mem_address !== m_addr || da_index !== m_index) begin
                mismatched++; $display("FAIL rand.ctx n=%0d addr/idx got=%h/%0d exp=%h/%0d", n, mem_address, da_index, m_addr, m_index); end
            if (m_op == 2) begin
                compared++; if (mem_wdata !== m_evict[m_beat*64 +: 64]) begin
                    mismatched++; $display("FAIL rand.wdata n=%0d got=%h exp=%h", n, mem_wdata, m_evict[m_beat*64 +: 64]); end
            end
            if (m_op == 3 && m_kind == 1) begin
                compared++; if (tb_array[m_index] !== m_fill_line) begin
                    mismatched++; $display("FAIL rand.line n=%0d got=%h exp=%h", n, tb_array[m_index], m_fill_line); end
            end
            tick();
        end
        quiet_inputs();
        finish_op();
        tick();
    endtask

    initial begin
        m_op = 0; m_kind = 0; m_beat = 0; m_addr = 0; m_index = 0;
        m_evict = 0; m_fill_line = 0;
        quiet_inputs();
        test_reset();
        test_fill();
        test_writeback();
        test_priority();
        test_reset_mid();
        test_hold_request();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
